// File: rtl/stego_pkg.sv
// Shared constants and state encoding for the stego encode/decode path.
// The encoder imports this too, so the pixel-to-bit mapping lives here once.
package stego_pkg;

    localparam int IMG_DIM   = 64;
    localparam int PIX_CNT   = IMG_DIM * IMG_DIM;
    localparam int MSG_BYTES = PIX_CNT / 8;
    localparam int GRAY_LSB  = 8;
    localparam int AW        = $clog2(PIX_CNT);
    localparam int DW        = $clog2(IMG_DIM);
    localparam int LW        = $clog2(MSG_BYTES) + 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DONE
    } state_t;

endpackage

// File: rtl/stego_decode_msg_len_tracker.sv
// Assembles captured bits LSB-first into bytes and records the index
// of the first all-zero byte; reports a full-length message if none.
module msg_len_tracker
    import stego_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_bit,
    input  logic          i_bit_valid,
    input  logic [AW-1:0] i_p,
    output logic [LW-1:0] o_msg_len
);

    logic [6:0]    r_sh;
    logic          r_found;
    logic [LW-1:0] r_len;
    logic [7:0]    w_byte;
    logic          w_last;

    assign w_byte    = {i_bit, r_sh};
    assign w_last    = (i_p == AW'(PIX_CNT - 1));
    assign o_msg_len = r_len;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_sh    <= '0;
            r_found <= 1'b0;
            r_len   <= '0;
        end else if (i_bit_valid) begin
            r_sh <= w_byte[7:1];
            if (i_p[2:0] == 3'd7 && !r_found) begin
                if (w_byte == 8'h00) begin
                    r_len   <= LW'(i_p[AW-1:3]);
                    r_found <= 1'b1;
                end else if (w_last) begin
                    r_len <= LW'(MSG_BYTES);
                end
            end
        end
    end

endmodule

// File: rtl/stego_decode.sv
// Reads the 64x64 stego image in row-major order and recovers the
// hidden bit string from each pixel's gray LSB, plus the message length.
module stego_decode
    import stego_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [23:0]        i_in_pix,
    output logic [DW-1:0]      o_row,
    output logic [DW-1:0]      o_col,
    output logic [PIX_CNT-1:0] o_hidden_string,
    output logic [LW-1:0]      o_msg_len,
    output logic               o_decode_done
);

    state_t             r_state;
    logic [AW-1:0]      r_addr;
    logic               r_issue;
    logic               r_cap_v;
    logic [AW-1:0]      r_cap_idx;
    logic               r_fin;
    logic [PIX_CNT-1:0] r_hidden;
    logic               r_done;

    logic w_clear;
    logic w_bit;
    logic w_bit_valid;
    logic w_unused_pix;

    assign w_bit        = i_in_pix[GRAY_LSB];
    assign w_unused_pix = ^{i_in_pix[23:9], i_in_pix[7:0]};
    assign w_clear      = i_start && (r_state != READ);
    assign w_bit_valid  = r_cap_v && (r_state == READ);

    assign o_row           = r_addr[AW-1:DW];
    assign o_col           = r_addr[DW-1:0];
    assign o_hidden_string = r_hidden;
    assign o_decode_done   = r_done;

    // r_cap_idx trails the address by one cycle to match memory latency
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_issue   <= 1'b0;
            r_cap_v   <= 1'b0;
            r_cap_idx <= '0;
            r_fin     <= 1'b0;
            r_hidden  <= '0;
            r_done    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_state  <= READ;
                        r_addr   <= '0;
                        r_issue  <= 1'b1;
                        r_cap_v  <= 1'b0;
                        r_fin    <= 1'b0;
                        r_hidden <= '0;
                        r_done   <= 1'b0;
                    end
                end
                READ: begin
                    if (r_issue) begin
                        if (r_addr == AW'(PIX_CNT - 1))
                            r_issue <= 1'b0;
                        else
                            r_addr <= r_addr + 1'b1;
                    end
                    r_cap_v   <= r_issue;
                    r_cap_idx <= r_addr;
                    if (r_cap_v)
                        r_hidden[r_cap_idx] <= w_bit;
                    r_fin <= r_cap_v
                          && (r_cap_idx == AW'(PIX_CNT - 1));
                    if (r_fin) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    msg_len_tracker u_len (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (w_clear),
        .i_bit       (w_bit),
        .i_bit_valid (w_bit_valid),
        .i_p         (r_cap_idx),
        .o_msg_len   (o_msg_len)
    );

endmodule

// File: tb/tb_stego_decode.sv
// Scoreboard bench for stego_decode: directed images, a synchronous
// image memory model, and a monitor checking each completed pass.
module tb_stego_decode;
    import stego_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [23:0]   pix;
    logic [5:0]    row;
    logic [5:0]    col;
    logic [4095:0] hs;
    logic [9:0]    len;
    logic          done;

    always #5 clk = ~clk;

    stego_decode dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .i_in_pix        (pix),
        .o_row           (row),
        .o_col           (col),
        .o_hidden_string (hs),
        .o_msg_len       (len),
        .o_decode_done   (done)
    );

    logic [23:0] mem [4096];
    always @(posedge clk) pix <= mem[{row, col}];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4095:0] hs;
        logic [9:0]    len;
        int            dc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   t0 = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per rising edge of decode_done
    logic prev_done = 1'b0;
    exp_t m_e;
    int   m_fb;
    always @(negedge clk) begin
        if (done === 1'b1 && prev_done !== 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done at %0d want none",
                         cyc);
            end else begin
                m_e = sb.pop_front();
                chk("latency", cyc, m_e.dc);
                chk("msg_len", 32'(len), 32'(m_e.len));
                chk("rowcol_hold", 32'({row, col}), 32'hFFF);
                n_vec++;
                if (hs !== m_e.hs) begin
                    n_err++;
                    m_fb = -1;
                    for (int i = 0; i < 4096; i++)
                        if (m_fb < 0 && hs[i] !== m_e.hs[i]) m_fb = i;
                    $display("FAIL hidden_string: bit %0d got %b want %b",
                             m_fb, hs[m_fb], m_e.hs[m_fb]);
                end
            end
        end
        prev_done = done;
    end

    task automatic load(input logic [4095:0] b, input bit noise);
        for (int p = 0; p < 4096; p++) begin
            logic [23:0] w;
            w = noise ? 24'($urandom) : 24'h0;
            w[8] = b[p];
            mem[p] = w;
        end
    endtask

    task automatic pulse();
        @(negedge clk);
        start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic poke();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expect_pass(input logic [4095:0] b, input logic [9:0] l);
        exp_t e;
        e.hs = b;
        e.len = l;
        e.dc = t0 + 4098;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int k = 0;
        while (done !== 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("done_timeout", 32'(done), 32'h1);
        @(negedge clk);
    endtask

    function automatic logic [9:0] first_nul(input logic [4095:0] b);
        for (int k = 0; k < 512; k++)
            if (b[8*k +: 8] == 8'h00) return 10'(k);
        return 10'd512;
    endfunction

    logic [4095:0] b;
    int errs;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        load('0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_row", 32'(row), 32'h0);
        chk("rst_col", 32'(col), 32'h0);
        chk("rst_hs_nz", 32'(|hs), 32'h0);
        chk("rst_len", 32'(len), 32'h0);
        chk("rst_done", 32'(done), 32'h0);

        // all-zero image
        load('0, 1'b0);
        pulse();
        expect_pass('0, 10'd0);
        wait_done();

        // alternating columns -> 0xAA bytes, plus address sweep
        b = {512{8'hAA}};
        load(b, 1'b1);
        pulse();
        expect_pass(b, 10'd512);
        errs = 0;
        for (int p = 0; p < 4096; p++) begin
            if (p != 0) @(negedge clk);
            if ({row, col} !== 12'(p)) errs++;
        end
        chk("sweep_errs", errs, 0);
        wait_done();

        // "HI", NUL, then non-zero filler
        b = {512{8'h55}};
        b[7:0] = 8'h48;
        b[15:8] = 8'h49;
        b[23:16] = 8'h00;
        load(b, 1'b1);
        pulse();
        expect_pass(b, 10'd2);
        wait_done();
        chk("hi_bytes", 32'(hs[15:0]), 32'h4948);

        // terminator in the very last byte
        b = {512{8'h5A}};
        b[4095:4088] = 8'h00;
        load(b, 1'b1);
        pulse();
        expect_pass(b, 10'd511);
        wait_done();

        // reset in the middle of a pass
        b = {512{8'hAA}};
        load(b, 1'b1);
        pulse();
        repeat (1000) @(negedge clk);
        chk("partial_nz", 32'(|hs), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_row", 32'(row), 32'h0);
        chk("mid_rst_col", 32'(col), 32'h0);
        chk("mid_rst_hs", 32'(|hs), 32'h0);
        chk("mid_rst_done", 32'(done), 32'h0);
        chk("mid_rst_len", 32'(len), 32'h0);
        pulse();
        expect_pass(b, 10'd512);
        wait_done();

        // restart from DONE, with an ignored start during READ
        pulse();
        chk("done_drop", 32'(done), 32'h0);
        expect_pass(b, 10'd512);
        repeat (200) @(negedge clk);
        poke();
        wait_done();

        // loopback of a random hidden string
        for (int i = 0; i < 128; i++) b[32*i +: 32] = $urandom;
        load(b, 1'b1);
        pulse();
        expect_pass(b, first_nul(b));
        wait_done();

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stego_decode.md
# stego_decode

Extraction engine for the steganography path: reads a 64x64 stego image, produced by the `process` encoder, pixel by pixel through the same `row`/`col` addressing the encoder uses. It recovers the 4096-bit hidden string from the LSB of each pixel's gray channel. It also reports the message length in characters, counted up to the first NUL byte. It sits on the read port of the image memory, in place of the encoder, for readback/verification flows.

## Interface
- `IMG_DIM`, 64: image side in pixels; `row`/`col` width is log2(IMG_DIM).
- `MSG_BITS`, 4096: hidden string width; equals IMG_DIM*IMG_DIM.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a decode pass.
- `in_pix`  in  24  pixel read from the image memory, {R[23:16], G[15:8], B[7:0]}.
- `row`  out  6  pixel row address to the image memory.
- `col`  out  6  pixel column address to the image memory.
- `hidden_string`  out  4096  recovered message; bit p from pixel p.
- `msg_len`  out  10  count of bytes before the first 0x00 byte; 0..512.
- `decode_done`  out  1  level; high while the results are valid.

## Operation
- Reset: state IDLE, `row`=`col`=0, `hidden_string`=0, `msg_len`=0, `decode_done`=0.
- States:
  - IDLE: waits; `start` -> READ.
  - READ: issues addresses 0..4095 and captures pixels; after the last capture -> DONE.
  - DONE: holds results; `start` -> READ.
- Addressing: pixel index p = row*64 + col, row-major. `col` increments each cycle and wraps 63->0 with `row`+1. Address generation stops after p=4095; `row`/`col` hold at 63/63.
- Extraction: payload bit = `in_pix[8]` (gray LSB, G channel). `hidden_string[p]` <= that bit. Message byte k = `hidden_string[8k+7:8k]`, first character at k=0.
- On entry to READ: `hidden_string`, `msg_len` and `decode_done` clear to 0.
- Length tracking:
  - On capture of p with p[2:0]==7, the assembled byte is checked.
  - If the byte is 0x00 and no terminator has been found yet: `msg_len` <= p>>3 and the found flag is set.
  - If no terminator is found by the end of the pass, `msg_len` = 512.
- `start` in READ is ignored. `start` in DONE restarts the pass, and `decode_done` falls on the next cycle.
- `rst` mid-pass: immediate return to IDLE with all reset values. Partial data is discarded.

## Timing
- The image memory is synchronous with 1-cycle read latency: address presented in cycle t, `in_pix` valid in cycle t+1, captured at the end of t+1.
- `start` sampled at edge E0. Address p is driven during cycles E0+1+p, for p = 0..4095. Pixel p is captured at edge E0+2+p.
- `decode_done` rises at edge E0+4098. The pass takes 4098 cycles from start to done.
- `hidden_string` bits update one per cycle during READ. They are stable only while `decode_done`=1.
- `msg_len` is final when `decode_done` rises.
- Simultaneous `rst` and `start`: reset wins.

## Structure
- Package `stego_pkg` holds:
  - constants IMG_DIM, PIX_CNT=4096, MSG_BYTES=512, GRAY_LSB=8;
  - the state enum {IDLE, READ, DONE}.
- The encoder uses the same package so the bit mapping has one definition.
- Sub-module `msg_len_tracker` handles the byte assembly, terminator detect and found flag. Its inputs are clk, rst, clear, bit, bit_valid, and p[11:0]; its output is msg_len.
- The top level holds the FSM, the address counter, a 1-cycle delayed capture index, and the 4096-bit capture register.

## Test plan
- All-zero image, `start` pulse -> `decode_done` high exactly 4098 cycles later; `hidden_string`=0; `msg_len`=0.
- Image with `in_pix[8]` = 1 for odd `col`, else 0 -> every byte 0xAA; `msg_len`=512; `row`/`col` sweep 0/0..63/63 in order.
- Pixels encode "HI" then 0x00 bytes -> `hidden_string[15:0]`=16'h4948; `msg_len`=2.
- `rst` asserted at cycle 1000 of READ -> next cycle state IDLE, `row`=`col`=0, `hidden_string`=0. A new `start` then completes normally in 4098 cycles.
- `start` pulsed again at cycle 200 of READ -> ignored; done still at 4098. `start` in DONE -> done drops one cycle later and the pass repeats.
- Loopback: `process` encodes a random 4096-bit `hiding_string` into a memory model; `stego_decode` reads that memory -> `hidden_string` equals the input bit-for-bit.
